// File: rtl/alu_seq_if.sv
// Command/response and downstream ALU8 signals of alu_seq.
// out_zero exists only when ALU_SEQ_ZFLAG_EN is defined.
interface alu_seq_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_cmd;
    logic [7:0] in_data;
    logic [2:0] alu_mode;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_x;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_err;
`ifdef ALU_SEQ_ZFLAG_EN
    logic       out_zero;

    modport slave (
        input  in_valid, in_cmd, in_data, alu_x, out_ready,
        output in_ready, alu_mode, alu_a, alu_b, out_valid, out_data, out_err, out_zero
    );

    modport master (
        output in_valid, in_cmd, in_data, alu_x, out_ready,
        input  in_ready, alu_mode, alu_a, alu_b, out_valid, out_data, out_err, out_zero
    );
`else
    modport slave (
        input  in_valid, in_cmd, in_data, alu_x, out_ready,
        output in_ready, alu_mode, alu_a, alu_b, out_valid, out_data, out_err
    );

    modport master (
        output in_valid, in_cmd, in_data, alu_x, out_ready,
        input  in_ready, alu_mode, alu_a, alu_b, out_valid, out_data, out_err
    );
`endif
endinterface

// File: rtl/alu_seq.sv
// Sequencer wrapping an external combinational ALU8 around an 8-bit accumulator.
// Optional zero flag output enabled by macro ALU_SEQ_ZFLAG_EN.
module alu_seq #(
    parameter logic [7:0] ACC_INIT = 8'h00
) (
    input logic       clk,
    input logic       rst,
    alu_seq_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e     state_q, state_d;
    logic [3:0] cmd_q;
    logic [7:0] opnd_q;
    logic [7:0] acc_q, acc_d;
    logic       err_q, err_d;
    logic       capture;
    logic       update;
    logic       mode_legal;

    assign mode_legal = (cmd_q[2:0] <= 3'd4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        update  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    capture = 1'b1;
                    state_d = StExec;
                end
            end
            StExec: begin
                update  = 1'b1;
                state_d = StDone;
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // LOAD bypasses the ALU; an illegal mode leaves the accumulator untouched.
    always_comb begin
        acc_d = acc_q;
        err_d = 1'b0;
        if (cmd_q[3]) begin
            acc_d = opnd_q;
        end else if (mode_legal) begin
            acc_d = bus.alu_x;
        end else begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_q  <= 4'h0;
            opnd_q <= 8'h00;
            acc_q  <= ACC_INIT;
            err_q  <= 1'b0;
        end else begin
            if (capture) begin
                cmd_q  <= bus.in_cmd;
                opnd_q <= bus.in_data;
            end
            if (update) begin
                acc_q <= acc_d;
                err_q <= err_d;
            end
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.out_data  = acc_q;
    assign bus.out_err   = err_q;
    assign bus.alu_mode  = cmd_q[2:0];
    assign bus.alu_a     = acc_q;
    assign bus.alu_b     = opnd_q;

`ifdef ALU_SEQ_ZFLAG_EN
    assign bus.out_zero = (acc_q == 8'h00);
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: behavioural accumulator model, ALU8 stand-in,
// per-cycle response monitor plus hand-computed literal expectations.
module tb_alu_seq;

    localparam logic [7:0] ACC_INIT = 8'h00;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    logic [7:0] m_acc     = ACC_INIT;
    logic [7:0] exp_data  = ACC_INIT;
    logic       exp_err   = 1'b0;
    logic       pending   = 1'b0;

    alu_seq_if bus ();

    alu_seq #(.ACC_INIT(ACC_INIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_ref(input logic [2:0] mode, input logic [7:0] a,
                                           input logic [7:0] b);
        case (mode)
            3'd0:    return a + b;
            3'd1:    return a & b;
            3'd2:    return a | b;
            3'd3:    return a ^ b;
            3'd4:    return ~(a ^ b);
            default: return 8'hA5;
        endcase
    endfunction

    assign bus.alu_x = alu_ref(bus.alu_mode, bus.alu_a, bus.alu_b);

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Any visible response must match the model's pending result.
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            chk("mon_pending", {7'd0, pending}, 8'd1);
            chk("mon_data", bus.out_data, exp_data);
            chk("mon_err", {7'd0, bus.out_err}, {7'd0, exp_err});
            chk("mon_in_ready", {7'd0, bus.in_ready}, 8'd0);
`ifdef ALU_SEQ_ZFLAG_EN
            chk("mon_zero", {7'd0, bus.out_zero}, {7'd0, exp_data == 8'h00});
`endif
        end
    end

    task automatic run_cmd(input logic [3:0] cmd, input logic [7:0] data, input int hold,
                           input bit noise, input logic [7:0] lit_data, input logic lit_err);
        logic [7:0] prev;
        @(negedge clk);
        chk("accept_ready", {7'd0, bus.in_ready}, 8'd1);
        bus.in_valid = 1'b1;
        bus.in_cmd   = cmd;
        bus.in_data  = data;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        prev = m_acc;
        if (cmd[3]) begin
            m_acc   = data;
            exp_err = 1'b0;
        end else if (cmd[2:0] <= 3'd4) begin
            m_acc   = alu_ref(cmd[2:0], m_acc, data);
            exp_err = 1'b0;
        end else begin
            exp_err = 1'b1;
        end
        exp_data = m_acc;
        pending  = 1'b1;
        @(negedge clk);
        chk("exec_out_valid", {7'd0, bus.out_valid}, 8'd0);
        chk("exec_in_ready", {7'd0, bus.in_ready}, 8'd0);
        chk("exec_alu_mode", {5'd0, bus.alu_mode}, {5'd0, cmd[2:0]});
        chk("exec_alu_a", bus.alu_a, prev);
        chk("exec_alu_b", bus.alu_b, data);
        @(negedge clk);
        chk("latency_valid", {7'd0, bus.out_valid}, 8'd1);
        chk("lit_data", bus.out_data, lit_data);
        chk("lit_err", {7'd0, bus.out_err}, {7'd0, lit_err});
        for (int i = 0; i < hold; i++) begin
            if (noise) begin
                bus.in_valid = 1'b1;
                bus.in_cmd   = 4'h8;
                bus.in_data  = 8'h99;
            end
            @(negedge clk);
            chk("hold_valid", {7'd0, bus.out_valid}, 8'd1);
            chk("hold_data", bus.out_data, lit_data);
            chk("hold_in_ready", {7'd0, bus.in_ready}, 8'd0);
            chk("hold_no_capture", bus.alu_b, data);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        pending       = 1'b0;
        @(negedge clk);
        chk("post_valid", {7'd0, bus.out_valid}, 8'd0);
        chk("post_in_ready", {7'd0, bus.in_ready}, 8'd1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_cmd    = 4'h0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {7'd0, bus.in_ready}, 8'd1);
        chk("rst_out_valid", {7'd0, bus.out_valid}, 8'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("init_acc", bus.alu_a, ACC_INIT);
        chk("init_opnd", bus.alu_b, 8'h00);
        chk("init_mode", {5'd0, bus.alu_mode}, 8'h00);
        chk("init_err", {7'd0, bus.out_err}, 8'd0);
`ifdef ALU_SEQ_ZFLAG_EN
        chk("init_zero", {7'd0, bus.out_zero}, 8'd1);
`endif

        // out_ready while idle must not disturb anything.
        bus.out_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("idle_out_ready_valid", {7'd0, bus.out_valid}, 8'd0);
            chk("idle_out_ready_rdy", {7'd0, bus.in_ready}, 8'd1);
        end
        bus.out_ready = 1'b0;

        run_cmd(4'h8, 8'h3C, 0, 1'b0, 8'h3C, 1'b0);
        run_cmd(4'h0, 8'h0F, 0, 1'b0, 8'h4B, 1'b0);
        run_cmd(4'h1, 8'hF0, 0, 1'b0, 8'h40, 1'b0);
        run_cmd(4'h4, 8'h40, 0, 1'b0, 8'hFF, 1'b0);
        run_cmd(4'h0, 8'h02, 0, 1'b0, 8'h01, 1'b0);
        run_cmd(4'h8, 8'hFF, 0, 1'b0, 8'hFF, 1'b0);
        run_cmd(4'h3, 8'hFF, 0, 1'b0, 8'h00, 1'b0);
        run_cmd(4'h2, 8'h0A, 0, 1'b0, 8'h0A, 1'b0);
        run_cmd(4'h8, 8'h55, 0, 1'b0, 8'h55, 1'b0);
        run_cmd(4'h6, 8'h11, 0, 1'b0, 8'h55, 1'b1);
        run_cmd(4'h2, 8'h0A, 0, 1'b0, 8'h5F, 1'b0);
        run_cmd(4'h8, 8'h12, 5, 1'b1, 8'h12, 1'b0);
        run_cmd(4'h0, 8'h01, 0, 1'b0, 8'h13, 1'b0);

        // Reset pulse while the command is executing aborts it.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_cmd   = 4'h0;
        bus.in_data  = 8'h20;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("abort_in_exec", {7'd0, bus.in_ready}, 8'd0);
        rst = 1'b1;
        #1;
        chk("abort_async_ready", {7'd0, bus.in_ready}, 8'd1);
        chk("abort_async_acc", bus.alu_a, ACC_INIT);
        chk("abort_async_opnd", bus.alu_b, 8'h00);
        #1;
        rst   = 1'b0;
        m_acc = ACC_INIT;
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_valid", {7'd0, bus.out_valid}, 8'd0);
        end
        chk("abort_acc", bus.alu_a, ACC_INIT);

        run_cmd(4'h0, 8'h07, 0, 1'b0, 8'h07, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
